// File: rtl/tt_um_serial_accumulator.sv
// Bit-serial 8-bit accumulator: acc <= acc + A, one bit per cycle, LSB first.
// Result and overflow are published only when the eighth bit completes.
module tt_um_serial_accumulator (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  acc_q, acc_d;
  logic        carry_q, carry_d;
  logic [7:0]  res_q, res_d;
  logic        ovf_q, ovf_d;

  logic        start;
  logic        clear;
  logic        busy;
  logic        done;
  logic        unused_ok;

  assign start     = uio_in[0];
  assign clear     = uio_in[1];
  assign unused_ok = &{1'b0, ena, uio_in[7:2]};

  // Full adder as two half-adder stages.
  logic h1_s, h1_c, h2_c;
  logic sum_b, cout_b;

  assign h1_s   = op_q[0] ^ acc_q[0];
  assign h1_c   = op_q[0] & acc_q[0];
  assign sum_b  = h1_s ^ carry_q;
  assign h2_c   = h1_s & carry_q;
  assign cout_b = h1_c | h2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!clear && start) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_ADD);
    done = (state_q == S_DONE);
  end

  logic idle_clr;
  logic idle_go;

  assign idle_clr = (state_q == S_IDLE) && clear;
  assign idle_go  = (state_q == S_IDLE) && !clear && start;

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      idle_clr: begin
        acc_d = 8'h00;
        res_d = 8'h00;
        ovf_d = 1'b0;
      end
      idle_go: begin
        op_d    = ui_in;
        cnt_d   = 3'd0;
        carry_d = 1'b0;
      end
      busy: begin
        acc_d   = {sum_b, acc_q[7:1]};
        op_d    = {1'b0, op_q[7:1]};
        carry_d = cout_b;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          res_d = {sum_b, acc_q[7:1]};
          ovf_d = cout_b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      op_q    <= 8'h00;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      res_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {1'b0, ovf_q, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_accumulator.sv
// Bench for the serial accumulator: vector table, random adds against a
// reference model, and hand-written sequences for reset/clear/timing cases.
module tb_tt_um_serial_accumulator;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_serial_accumulator dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       clr;
    logic [7:0] a;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[7];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_acc  = 8'h00;
  logic [7:0] m_res  = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    uio_in = 8'h02;
    @(negedge clk);
    uio_in = 8'h00;
    check("clear_res", uo_out, 8'h00);
    check("clear_ovf", uio_out[6], 0);
    check("clear_nobusy", uio_out[4], 0);
    m_acc = 8'h00;
    m_res = 8'h00;
  endtask

  task automatic do_add(input logic [7:0] a, input logic [7:0] er,
                        input logic eo, input bit noise, input bit clr_done);
    exp_t e;
    int   busy_n;
    bit   seen;
    e.res = er;
    e.ovf = eo;
    sb.push_back(e);
    m_acc = er;
    @(negedge clk);
    ui_in  = a;
    uio_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    uio_in = 8'h00;
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (uio_out[5]) begin
        seen = 1;
      end else if (uio_out[4]) begin
        busy_n++;
        check("hold_during_add", uo_out, m_res);
        if (noise) begin
          ui_in  = 8'($urandom);
          uio_in = {6'b0, i[0], 1'b1};
        end
      end
    end
    uio_in = clr_done ? 8'h02 : 8'h00;
    ui_in  = 8'h00;
    check("busy_cycles", busy_n, 8);
    check("done_seen", seen, 1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("result", uo_out, e.res);
      check("ovf", uio_out[6], e.ovf);
    end
    m_res = er;
    @(negedge clk);
    check("done_pulse_1cyc", uio_out[5:4], 0);
    check("res_after_done", uo_out, er);
    if (clr_done) begin
      @(negedge clk);
      uio_in = 8'h00;
      check("clr_held_into_idle", uo_out, 8'h00);
      m_acc = 8'h00;
      m_res = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [8:0] s;
    int         d1;
    int         d2;
    int         k;
    exp_t       e;

    tbl[0] = '{clr: 1'b1, a: 8'h05, res: 8'h05, ovf: 1'b0};
    tbl[1] = '{clr: 1'b0, a: 8'hFF, res: 8'h04, ovf: 1'b1};
    tbl[2] = '{clr: 1'b0, a: 8'h01, res: 8'h05, ovf: 1'b0};
    tbl[3] = '{clr: 1'b1, a: 8'h80, res: 8'h80, ovf: 1'b0};
    tbl[4] = '{clr: 1'b0, a: 8'h80, res: 8'h00, ovf: 1'b1};
    tbl[5] = '{clr: 1'b0, a: 8'h7F, res: 8'h7F, ovf: 1'b0};
    tbl[6] = '{clr: 1'b0, a: 8'h81, res: 8'h00, ovf: 1'b1};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_uio_oe", uio_oe, 8'hF0);

    foreach (tbl[i]) begin
      if (tbl[i].clr) do_clear();
      do_add(tbl[i].a, tbl[i].res, tbl[i].ovf, 0, 0);
    end

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      s = {1'b0, m_acc} + {1'b0, a};
      do_add(a, s[7:0], s[8], 0, 0);
    end

    // start and clear together: clear wins, no add starts
    do_add(8'h21, m_acc + 8'h21, ({1'b0, m_acc} + 9'h21) > 9'hFF, 0, 0);
    @(negedge clk);
    uio_in = 8'h03;
    ui_in  = 8'h44;
    @(negedge clk);
    uio_in = 8'h00;
    check("start_clr_nobusy", uio_out[4], 0);
    check("start_clr_res", uo_out, 8'h00);
    m_acc = 8'h00;
    m_res = 8'h00;
    do_add(8'h01, 8'h01, 0, 0, 0);

    // noisy ui_in and clear during ADD
    do_add(8'h10, 8'h11, 0, 1, 0);
    do_add(8'hF0, 8'h01, 1, 1, 0);

    // clear during DONE ignored, held into IDLE acts
    do_add(8'h09, 8'h0A, 0, 0, 1);

    // continuous start: back-to-back ops every 10 cycles
    e.res = m_acc + 8'h02;
    e.ovf = 1'b0;
    sb.push_back(e);
    e.res = m_acc + 8'h04;
    sb.push_back(e);
    @(negedge clk);
    ui_in  = 8'h02;
    uio_in = 8'h01;
    d1 = -1;
    d2 = -1;
    k  = 0;
    while (d2 < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (uio_out[5]) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("b2b_result", uo_out, e.res);
          check("b2b_ovf", uio_out[6], e.ovf);
        end
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          uio_in = 8'h00;
        end
      end
    end
    uio_in = 8'h00;
    check("b2b_period", d2 - d1, 10);
    m_acc = m_acc + 8'h04;
    m_res = m_acc;
    @(negedge clk);
    @(negedge clk);
    check("b2b_stopped", uio_out[4], 0);

    // reset mid-ADD aborts
    @(negedge clk);
    ui_in  = 8'h55;
    uio_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", uio_out[4], 1);
    rst_n = 1'b0;
    #1;
    check("abort_uo_out", uo_out, 8'h00);
    check("abort_uio_out", uio_out, 8'h00);
    check("abort_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 8'h00;
    m_res = 8'h00;
    do_add(8'h03, 8'h03, 0, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_accumulator.md
TT_UM_SERIAL_ACCUMULATOR -- requirements
Module: tt_um_serial_accumulator

Interface
REQ-001 SHALL provide clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  asynchronous, active-low reset; only reset in the block.
REQ-003 SHALL provide ena  input  1  power-good indication; ignored by the logic.
REQ-004 SHALL provide ui_in  input  8  operand A, sampled when an add starts.
REQ-005 SHALL provide uio_in  input  8  bit0 = start, bit1 = clear, bits 7:2 ignored.
REQ-006 SHALL provide uo_out  output  8  result register, the last completed accumulator value.
REQ-007 SHALL provide uio_out  output  8  bit4 = busy, bit5 = done, bit6 = ovf, bits 7 and 3:0 driven 0.
REQ-008 SHALL drive uio_oe constant 8'hF0: uio[7:4] outputs, uio[3:0] inputs.

Function
REQ-009 SHALL implement a bit-serial adder, LSB first, computing acc <= (acc + A) mod 256 over 8 add cycles.
- Each add cycle is one full-adder step built from two half-adder stages plus a carry flip-flop.
REQ-010 SHALL hold internal registers: state (IDLE, ADD, DONE), 3-bit bit counter, 8-bit operand shift register, 8-bit acc shift register, carry flop, 8-bit result register, ovf flop.
REQ-011 In IDLE with clear=1, the block SHALL set acc, result and ovf to 0 at the next edge and stay in IDLE; clear SHALL take priority over start.
REQ-012 In IDLE with start=1 and clear=0, the block SHALL do all of the following at the next edge:
- load the operand register with ui_in;
- set counter=0 and carry=0;
- enter ADD.
REQ-013 In ADD, every edge SHALL perform one step:
- sum = op[0] ^ acc[0] ^ carry;
- carry <= majority(op[0], acc[0], carry);
- acc shifts right with sum into bit 7;
- op shifts right;
- counter increments.
REQ-014 On the ADD edge where counter==7, the block SHALL do all of the following:
- load result with the final 8-bit sum (equal to the new acc);
- load ovf with the carry-out of the final step;
- enter DONE.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-016 busy SHALL be 1 exactly while state==ADD, which is 8 cycles per operation.
REQ-017 done SHALL be 1 exactly while state==DONE, a one-cycle pulse.
REQ-018 Latency: if start is sampled at edge N, result and ovf SHALL be updated at edge N+8, done SHALL be high between edges N+8 and N+9, and the next start SHALL be accepted no earlier than edge N+9.
REQ-019 start and clear SHALL be ignored while in ADD; operand A SHALL be sampled only at the start edge, so ui_in changes during ADD have no effect.
REQ-020 clear asserted in DONE SHALL be ignored; a clear held into the following IDLE cycle SHALL act there.
REQ-021 If start is held continuously high, the block SHALL begin a new operation each time it returns to IDLE, giving back-to-back operations every 10 cycles.
REQ-022 uo_out SHALL change only on completion, clear or reset; it SHALL never show partial shift values.
REQ-023 ovf SHALL reflect only the most recent completed addition and SHALL NOT be sticky.
REQ-024 Overflow SHALL wrap modulo 256 with no saturation.

Reset
REQ-025 While rst_n=0, the block SHALL immediately (asynchronously), without waiting for a clock edge:
- set state=IDLE;
- set counter, operand, acc, carry, result and ovf to 0;
- force uo_out=8'h00, busy=0, done=0.
REQ-026 uio_oe SHALL remain 8'hF0 during reset.
REQ-027 Reset asserted mid-ADD SHALL abort the operation with no result update; after release the block SHALL be idle with acc=0.
REQ-028 The first rising edge after rst_n deasserts SHALL be a normal operating edge.

Verification
REQ-029 Post-reset check: after reset, uo_out=0x00, uio_out=0x00 and uio_oe=0xF0 SHALL be observed.
REQ-030 Single add from zero: acc=0, pulse start with ui_in=0x05 -> busy for 8 cycles, done pulse at N+8, uo_out=0x05, ovf=0.
REQ-031 Wrap with overflow: from acc=0x05, add ui_in=0xFF -> uo_out=0x04, ovf=1; then add 0x01 -> uo_out=0x05, ovf=0.
REQ-032 Carry at MSB: clear, then add 0x80 twice -> uo_out=0x80 then 0x00 with ovf=1.
REQ-033 Priority and ignored inputs:
- start and clear together in IDLE -> acc cleared, no busy;
- ui_in toggled and clear pulsed during ADD -> result unaffected.
REQ-034 Abort and restart: rst_n pulsed low at ADD cycle 4 -> outputs zero immediately; the next add of 0x03 -> uo_out=0x03, ovf=0.
